// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO/beat widths and reader FSM state encoding
package fifo_pkg;
  localparam int DATA_W = 80;
  localparam int BEAT_W = 16;
  localparam int NUM_BEATS = DATA_W / BEAT_W;
  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, SEND} state_t;
endpackage

// File: rtl/fifo_reader.sv
// fifo_reader: fetches one FIFO word at a time and streams it out LSB-first as ready/valid beats
module fifo_reader import fifo_pkg::*; #(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int BEAT_W = fifo_pkg::BEAT_W
) (
  input  logic              read_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read_en,
  output logic [BEAT_W-1:0] beat_data,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic              beat_last,
  output logic [15:0]       words_read,
  output logic              busy
);
  localparam int NUM_BEATS = DATA_W / BEAT_W;
  localparam int IDX_W = $clog2(NUM_BEATS + 1);
  if (DATA_W % BEAT_W != 0) begin : g_bad_w
    $error("fifo_reader: DATA_W must be an integer multiple of BEAT_W");
  end
  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;
  // outputs are pure decodes of state and the shift register, so they hold still under backpressure
  always_comb begin
    fifo_read_en = state == FETCH;
    beat_valid   = state == SEND;
    beat_last    = state == SEND && idx == IDX_W'(NUM_BEATS - 1);
    beat_data    = shreg[BEAT_W-1:0];
    busy         = state != IDLE;
  end
  // fetch / capture / send sequencing; enable only gates leaving IDLE
  always_ff @(posedge read_clk)
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      idx        <= '0;
      words_read <= '0;
    end else begin
      unique case (state)
        IDLE:    if (enable && !fifo_empty) state <= FETCH;
        FETCH:   state <= CAPTURE;
        CAPTURE: begin
          shreg <= fifo_data;
          idx   <= '0;
          state <= SEND;
        end
        SEND:    if (beat_ready) begin
          shreg <= shreg >> BEAT_W;
          idx   <= idx + 1'b1;
          if (beat_last) begin
            words_read <= words_read + 1'b1;
            state      <= IDLE;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed stimulus with a beat scoreboard checked by an independent monitor
module tb_fifo_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [79:0] fifo_data = '0;
  logic        fifo_read_en;
  logic [15:0] beat_data;
  logic        beat_valid;
  logic        beat_ready = 1'b0;
  logic        beat_last;
  logic [15:0] words_read;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int go_cyc = 0;
  int rd_cyc = 0;
  int rd_cnt = 0;
  int nbeats = 0;
  bit pend = 0;
  logic [79:0] fq[$];
  logic [16:0] exp_q[$];
  int rd_q[$];

  fifo_reader dut (
    .read_clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read_en(fifo_read_en), .beat_data(beat_data),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_last(beat_last),
    .words_read(words_read), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO model: registered data one cycle after an accepted read
  always @(posedge clk) begin
    if (fifo_read_en && fq.size() > 0) begin
      fifo_data <= fq[0];
      fq.pop_front();
    end
    fifo_empty <= fq.size() == 0;
  end

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic push_word(logic [79:0] w, bit to_fifo);
    if (to_fifo) fq.push_back(w);
    for (int i = 0; i < 5; i++) exp_q.push_back({i == 4, w[i*16 +: 16]});
  endtask

  task automatic wait_words(logic [15:0] n);
    int k = 0;
    while (words_read != n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("words_read", words_read, n);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!beat_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("valid_timeout", beat_valid, 1);
  endtask

  // monitor: samples just before each rising edge, scores transfers, latency and stability
  initial begin
    logic        pv = 0, pr = 0, pl = 0, prst = 1, prd = 0;
    logic [15:0] pd = '0;
    logic [16:0] e;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (!rst && pv && !pr && !prst) begin
        chk("hold_valid", beat_valid, pv);
        chk("hold_data", beat_data, pd);
        chk("hold_last", beat_last, pl);
      end
      if (beat_last) chk("last_needs_valid", beat_valid, 1);
      if (rst) pend = 0;
      if (fifo_read_en) begin
        chk("rd_back_to_back", prd, 0);
        chk("fetch_lat", cyc - go_cyc, 1);
        rd_cnt++;
        rd_cyc = cyc;
        rd_q.push_back(cyc);
        pend = 1;
      end
      if (pend && beat_valid) begin
        chk("valid_lat", cyc - rd_cyc, 2);
        pend = 0;
      end
      if (!rst && beat_valid && beat_ready) begin
        nbeats++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h expected=none", beat_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", beat_data, e[15:0]);
          chk("beat_last", beat_last, e[16]);
        end
      end
      if (!rst && !busy && enable && !fifo_empty) go_cyc = cyc;
      pv = beat_valid; pr = beat_ready; pd = beat_data; pl = beat_last;
      prst = rst; prd = fifo_read_en;
    end
  end

  initial begin
    int rc0, nb0;
    repeat (2) @(negedge clk);
    chk("rst_read_en", fifo_read_en, 0);
    chk("rst_valid", beat_valid, 0);
    chk("rst_last", beat_last, 0);
    chk("rst_data", beat_data, 0);
    chk("rst_words", words_read, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    // single word
    beat_ready = 1;
    enable = 1;
    rc0 = rd_cnt;
    push_word(80'h0123_4567_89AB_CDEF_1122, 1);
    wait_words(1);
    chk("single_reads", rd_cnt - rc0, 1);
    @(negedge clk);
    chk("single_idle_valid", beat_valid, 0);
    // backpressure on beat 2
    rc0 = rd_cnt;
    push_word(80'h0123_4567_89AB_CDEF_1122, 1);
    wait_valid();
    @(negedge clk);
    beat_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_data", beat_data, 16'hCDEF);
      chk("bp_valid", beat_valid, 1);
      chk("bp_read_en", fifo_read_en, 0);
      @(negedge clk);
    end
    beat_ready = 1;
    wait_words(2);
    chk("bp_reads", rd_cnt - rc0, 1);
    // empty FIFO with enable high
    rc0 = rd_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("empty_busy", busy, 0);
      chk("empty_valid", beat_valid, 0);
    end
    chk("empty_reads", rd_cnt - rc0, 0);
    // enable drops during beat 3 while another word waits in the FIFO
    rc0 = rd_cnt;
    push_word(80'h5555_4444_3333_2222_1111, 1);
    fq.push_back(80'h9999_8888_7777_6666_A5A5);
    wait_valid();
    repeat (2) @(negedge clk);
    chk("drop_beat3", beat_data, 16'h3333);
    enable = 0;
    wait_words(3);
    repeat (12) @(negedge clk);
    chk("drop_reads", rd_cnt - rc0, 1);
    chk("drop_busy", busy, 0);
    // reset in the middle of the waiting word
    push_word(80'h9999_8888_7777_6666_A5A5, 0);
    enable = 1;
    wait_valid();
    @(negedge clk);
    chk("mid_beat2", beat_data, 16'h6666);
    rst = 1;
    chk("rst_cycle_rd", fifo_read_en, 0);
    @(negedge clk);
    rst = 0;
    exp_q.delete();
    chk("post_rst_valid", beat_valid, 0);
    chk("post_rst_words", words_read, 0);
    chk("post_rst_rd", fifo_read_en, 0);
    chk("post_rst_busy", busy, 0);
    push_word(80'hFEDC_BA98_7654_3210_0F0F, 1);
    wait_words(1);
    // three words back to back
    rd_q.delete();
    nb0 = nbeats;
    push_word(80'h1111_2222_3333_4444_5555, 1);
    push_word(80'hAAAA_BBBB_CCCC_DDDD_EEEE, 1);
    push_word(80'h0001_0002_0003_0004_0005, 1);
    wait_words(4);
    chk("tp_reads", rd_q.size(), 3);
    if (rd_q.size() == 3) begin
      chk("tp_gap0", rd_q[1] - rd_q[0], 8);
      chk("tp_gap1", rd_q[2] - rd_q[1], 8);
    end
    chk("tp_beats", nbeats - nb0, 15);
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 80, giving the FIFO word width in bits.
REQ-002 SHALL have parameter BEAT_W, default 16, giving the output beat width in bits; NUM_BEATS = DATA_W/BEAT_W (5 at defaults).
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
- read_clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  permits new word fetches.
- fifo_empty  input  1  empty flag from the FIFO read port.
- fifo_data  input  DATA_W  FIFO data_out; valid the cycle after an accepted read.
- fifo_read_en  output  1  read strobe to the FIFO.
- beat_data  output  BEAT_W  current output beat.
- beat_valid  output  1  beat_data valid.
- beat_ready  input  1  downstream accepts beat.
- beat_last  output  1  final beat of the current word.
- words_read  output  16  count of fully delivered words.
- busy  output  1  high whenever state is not IDLE.

Function
REQ-004 SHALL implement a FSM with states IDLE, FETCH, CAPTURE and SEND.
REQ-005 IDLE: SHALL move to FETCH when enable=1 and fifo_empty=0; otherwise SHALL stay in IDLE.
REQ-006 FETCH: SHALL assert fifo_read_en for exactly one cycle, then move to CAPTURE; fifo_read_en SHALL be 0 in every other state.
REQ-007 CAPTURE: SHALL load fifo_data into a DATA_W shift register, clear the beat index, and move to SEND.
REQ-008 SEND: SHALL drive beat_valid=1 and beat_data = shift register bits [BEAT_W-1:0]; the first beat carries the least-significant bits.
REQ-009 A beat SHALL transfer only on a cycle where beat_valid=1 and beat_ready=1; on transfer, the shift register shifts right by BEAT_W and the beat index increments.
REQ-010 While beat_ready=0, beat_data, beat_last and beat_valid SHALL remain stable.
REQ-011 beat_last SHALL equal 1 exactly when beat index = NUM_BEATS-1 in SEND.
REQ-012 On transfer of the last beat: words_read SHALL increment modulo 2^16 (0xFFFF wraps to 0x0000) and the FSM SHALL return to IDLE.
REQ-013 Latency: an IDLE cycle with enable=1 and fifo_empty=0 (cycle 0) SHALL give FETCH in cycle 1, CAPTURE in cycle 2, and the first beat_valid in cycle 3.
REQ-014 With beat_ready held at 1, back-to-back words SHALL take 8 cycles each.
REQ-015 Deasserting enable mid-word SHALL NOT abort that word; enable gates only the IDLE-to-FETCH transition.
REQ-016 At most one FIFO read SHALL be outstanding at any time; fifo_empty SHALL be ignored outside IDLE.
REQ-017 DATA_W not an integer multiple of BEAT_W SHALL produce an elaboration-time error.

Reset
REQ-018 With rst=1 at a read_clk edge, the block SHALL set:
- state = IDLE
- fifo_read_en = 0, beat_valid = 0, beat_last = 0
- beat_data = 0, shift register = 0, beat index = 0
- words_read = 0, busy = 0
REQ-019 Reset mid-word SHALL discard the remaining beats; no fifo_read_en SHALL be asserted during the reset cycle or the first cycle after it.

Structure
REQ-020 Package fifo_pkg SHALL hold DATA_W (80), BEAT_W (16), NUM_BEATS and the FSM state enum; the existing FIFO width SHALL come from the same constant.
REQ-021 The block SHALL be a single module with no sub-module; the shift register and counters are inline.

Verification
REQ-022 Single word:
- Stimulus: FIFO holds 80'h0123_4567_89AB_CDEF_1122; beat_ready=1.
- Response: beats 1122, CDEF, 89AB, 4567, 0123; beat_last on the 5th beat only; one read_en pulse in cycle 1; first beat_valid in cycle 3; words_read=1.
REQ-023 Backpressure:
- Stimulus: beat_ready=0 for 4 cycles while beat 2 is presented.
- Response: beat_data held at 16'hCDEF with beat_valid=1; no additional fifo_read_en.
REQ-024 Empty FIFO:
- Stimulus: fifo_empty=1 and enable=1 for 20 cycles.
- Response: fifo_read_en never asserted; busy=0; beat_valid=0.
REQ-025 Enable drop:
- Stimulus: enable falls during beat 3; fifo_empty=0.
- Response: word completes through beat_last; no new FETCH afterwards; words_read increments by 1.
REQ-026 Reset mid-word:
- Stimulus: rst pulsed for 1 cycle at beat 2.
- Response: next cycle beat_valid=0 and words_read=0; the next word restarts at its beat 0.
REQ-027 Throughput:
- Stimulus: 3 words queued; beat_ready=1.
- Response: read_en pulses exactly 8 cycles apart; 15 beats delivered; words_read=3.
